// File: rtl/mqnic_app_rx_psn_filter_pkg.sv
// Shared definitions for the RoCEv2 RX PSN filter.
// Holds the header byte offsets, protocol constants, the decision and FSM enums,
// and a saturating counter helper.
package mqnic_app_rx_psn_filter_pkg;

  // Byte offsets into the first beat (byte k is tdata[8k+7:8k]).
  localparam int unsigned ETHTYPE_OFS   = 12;
  localparam int unsigned IPPROTO_OFS   = 23;
  localparam int unsigned UDPDP_OFS     = 36;
  localparam int unsigned QPN_OFS       = 47;
  localparam int unsigned PSN_OFS       = 51;
  localparam int unsigned MIN_HDR_BYTES = 54;

  localparam logic [15:0] ETHTYPE_IPV4 = 16'h0800;
  localparam logic [7:0]  IPPROTO_UDP  = 8'h11;
  localparam logic [15:0] ROCEV2_PORT  = 16'h12B7;

  typedef enum logic [1:0] {
    DecPass,
    DecDup,
    DecSeqErr,
    DecBadQp
  } decision_e;

  typedef enum logic [1:0] {
    StFirst,
    StPass,
    StDrop
  } state_e;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/mqnic_app_roce_hdr_parse.sv
// Combinational RoCEv2 header parser for the first beat of a frame.
// Ports:
//   hdr_i      - the first MIN_HDR_BYTES bytes of beat 0
//   keep_i     - matching tkeep bits
//   is_roce_o  - IPv4 / UDP / dport 4791 with the full header present
//   qpn_o      - BTH destination QP (big-endian bytes 47..49)
//   psn_o      - BTH PSN (big-endian bytes 51..53)
module mqnic_app_roce_hdr_parse
  import mqnic_app_rx_psn_filter_pkg::*;
(
  input  logic [MIN_HDR_BYTES*8-1:0] hdr_i,
  input  logic [MIN_HDR_BYTES-1:0]   keep_i,
  output logic                       is_roce_o,
  output logic [23:0]                qpn_o,
  output logic [23:0]                psn_o
);

  logic [15:0] ethtype;
  logic [7:0]  ipproto;
  logic [15:0] udp_dport;

  assign ethtype   = {hdr_i[8*ETHTYPE_OFS +: 8], hdr_i[8*(ETHTYPE_OFS+1) +: 8]};
  assign ipproto   = hdr_i[8*IPPROTO_OFS +: 8];
  assign udp_dport = {hdr_i[8*UDPDP_OFS +: 8], hdr_i[8*(UDPDP_OFS+1) +: 8]};

  assign qpn_o = {hdr_i[8*QPN_OFS +: 8], hdr_i[8*(QPN_OFS+1) +: 8],
                  hdr_i[8*(QPN_OFS+2) +: 8]};
  assign psn_o = {hdr_i[8*PSN_OFS +: 8], hdr_i[8*(PSN_OFS+1) +: 8],
                  hdr_i[8*(PSN_OFS+2) +: 8]};

  assign is_roce_o = (keep_i == '1) && (ethtype == ETHTYPE_IPV4) &&
                     (ipproto == IPPROTO_UDP) && (udp_dport == ROCEV2_PORT);

  // Address and checksum bytes are carried but never inspected.
  logic unused_hdr;
  assign unused_hdr = ^hdr_i;

endmodule

// File: rtl/mqnic_app_rx_psn_filter.sv
// RoCEv2 RX PSN filter.
// Parses beat 0 of each frame, checks the BTH PSN against a per-QP expected PSN
// and forwards in-order frames through a single output register. Duplicate,
// future-PSN and out-of-range-QP frames are dropped whole and counted.
// Ports:
//   clk, rst            - clock, synchronous active-low reset
//   s_axis_rx_*         - input AXI-Stream (MAC side)
//   m_axis_rx_*         - output AXI-Stream (to RX data processor)
//   psn_check_en        - 0 bypasses checking and table updates
//   cfg_wr_*            - expected-PSN table write port
//   stat_*_cnt          - saturating 32-bit event counters
module mqnic_app_rx_psn_filter
  import mqnic_app_rx_psn_filter_pkg::*;
#(
  parameter int unsigned AXIS_DATA_WIDTH = 512,
  parameter int unsigned AXIS_KEEP_WIDTH = AXIS_DATA_WIDTH / 8,
  parameter int unsigned AXIS_ID_WIDTH   = 1,
  parameter int unsigned AXIS_DEST_WIDTH = 8,
  parameter int unsigned AXIS_USER_WIDTH = 96,
  parameter int unsigned QP_COUNT        = 16,
  parameter int unsigned QP_IDX_WIDTH    = $clog2(QP_COUNT)
) (
  input  logic                       clk,
  input  logic                       rst,

  input  logic [AXIS_DATA_WIDTH-1:0] s_axis_rx_tdata,
  input  logic [AXIS_KEEP_WIDTH-1:0] s_axis_rx_tkeep,
  input  logic                       s_axis_rx_tvalid,
  output logic                       s_axis_rx_tready,
  input  logic                       s_axis_rx_tlast,
  input  logic [AXIS_ID_WIDTH-1:0]   s_axis_rx_tid,
  input  logic [AXIS_DEST_WIDTH-1:0] s_axis_rx_tdest,
  input  logic [AXIS_USER_WIDTH-1:0] s_axis_rx_tuser,

  output logic [AXIS_DATA_WIDTH-1:0] m_axis_rx_tdata,
  output logic [AXIS_KEEP_WIDTH-1:0] m_axis_rx_tkeep,
  output logic                       m_axis_rx_tvalid,
  input  logic                       m_axis_rx_tready,
  output logic                       m_axis_rx_tlast,
  output logic [AXIS_ID_WIDTH-1:0]   m_axis_rx_tid,
  output logic [AXIS_DEST_WIDTH-1:0] m_axis_rx_tdest,
  output logic [AXIS_USER_WIDTH-1:0] m_axis_rx_tuser,

  input  logic                       psn_check_en,
  input  logic                       cfg_wr_en,
  input  logic [QP_IDX_WIDTH-1:0]    cfg_wr_qp,
  input  logic [23:0]                cfg_wr_psn,

  output logic [31:0]                stat_accept_cnt,
  output logic [31:0]                stat_dup_cnt,
  output logic [31:0]                stat_seq_err_cnt,
  output logic [31:0]                stat_bad_qp_cnt
);

  state_e state_q, state_d;

  logic [AXIS_DATA_WIDTH-1:0] m_tdata_q, m_tdata_d;
  logic [AXIS_KEEP_WIDTH-1:0] m_tkeep_q, m_tkeep_d;
  logic                       m_tvalid_q, m_tvalid_d;
  logic                       m_tlast_q, m_tlast_d;
  logic [AXIS_ID_WIDTH-1:0]   m_tid_q, m_tid_d;
  logic [AXIS_DEST_WIDTH-1:0] m_tdest_q, m_tdest_d;
  logic [AXIS_USER_WIDTH-1:0] m_tuser_q, m_tuser_d;

  logic [23:0] exp_q [QP_COUNT];
  logic [23:0] exp_d [QP_COUNT];

  logic [31:0] accept_cnt_q, accept_cnt_d;
  logic [31:0] dup_cnt_q, dup_cnt_d;
  logic [31:0] seq_err_cnt_q, seq_err_cnt_d;
  logic [31:0] bad_qp_cnt_q, bad_qp_cnt_d;

  logic                    is_roce;
  logic [23:0]             qpn;
  logic [23:0]             psn;
  logic [QP_IDX_WIDTH-1:0] qp_idx;
  logic [23:0]             psn_diff;
  logic                    roce_chk;
  logic                    s_hs;
  logic                    first_hs;
  logic                    fwd;
  decision_e               dec;

  mqnic_app_roce_hdr_parse u_hdr_parse (
    .hdr_i     (s_axis_rx_tdata[MIN_HDR_BYTES*8-1:0]),
    .keep_i    (s_axis_rx_tkeep[MIN_HDR_BYTES-1:0]),
    .is_roce_o (is_roce),
    .qpn_o     (qpn),
    .psn_o     (psn)
  );

  assign qp_idx   = qpn[QP_IDX_WIDTH-1:0];
  assign psn_diff = psn - exp_q[qp_idx];
  assign roce_chk = is_roce && psn_check_en;

  // Bit 23 of the modular difference set means the PSN is behind expected.
  always_comb begin
    dec = DecPass;
    if (roce_chk) begin
      if ((qpn >> QP_IDX_WIDTH) != 24'd0) begin
        dec = DecBadQp;
      end else if (psn_diff == 24'd0) begin
        dec = DecPass;
      end else if (psn_diff[23]) begin
        dec = DecDup;
      end else begin
        dec = DecSeqErr;
      end
    end
  end

  assign s_axis_rx_tready = rst && ((state_q == StDrop) || !m_tvalid_q || m_axis_rx_tready);
  assign s_hs     = s_axis_rx_tvalid && s_axis_rx_tready;
  assign first_hs = s_hs && (state_q == StFirst);
  assign fwd      = s_hs && ((state_q == StPass) || ((state_q == StFirst) && (dec == DecPass)));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StFirst: begin
        if (s_hs && !s_axis_rx_tlast) begin
          state_d = (dec == DecPass) ? StPass : StDrop;
        end
      end
      StPass, StDrop: begin
        if (s_hs && s_axis_rx_tlast) begin
          state_d = StFirst;
        end
      end
      default: state_d = StFirst;
    endcase
  end

  always_comb begin
    m_tdata_d  = m_tdata_q;
    m_tkeep_d  = m_tkeep_q;
    m_tvalid_d = m_tvalid_q && !m_axis_rx_tready;
    m_tlast_d  = m_tlast_q;
    m_tid_d    = m_tid_q;
    m_tdest_d  = m_tdest_q;
    m_tuser_d  = m_tuser_q;
    if (fwd) begin
      m_tdata_d  = s_axis_rx_tdata;
      m_tkeep_d  = s_axis_rx_tkeep;
      m_tvalid_d = 1'b1;
      m_tlast_d  = s_axis_rx_tlast;
      m_tid_d    = s_axis_rx_tid;
      m_tdest_d  = s_axis_rx_tdest;
      m_tuser_d  = s_axis_rx_tuser;
    end
  end

  // The cfg write is applied last so it wins over a same-cycle packet update.
  always_comb begin
    exp_d = exp_q;
    if (first_hs && roce_chk && (dec == DecPass)) begin
      exp_d[qp_idx] = exp_q[qp_idx] + 24'd1;
    end
    if (cfg_wr_en) begin
      exp_d[cfg_wr_qp] = cfg_wr_psn;
    end
  end

  always_comb begin
    accept_cnt_d  = accept_cnt_q;
    dup_cnt_d     = dup_cnt_q;
    seq_err_cnt_d = seq_err_cnt_q;
    bad_qp_cnt_d  = bad_qp_cnt_q;
    if (first_hs && roce_chk) begin
      unique case (dec)
        DecPass:   accept_cnt_d  = sat_inc(accept_cnt_q);
        DecDup:    dup_cnt_d     = sat_inc(dup_cnt_q);
        DecSeqErr: seq_err_cnt_d = sat_inc(seq_err_cnt_q);
        DecBadQp:  bad_qp_cnt_d  = sat_inc(bad_qp_cnt_q);
        default:   ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= StFirst;
      m_tdata_q     <= '0;
      m_tkeep_q     <= '0;
      m_tvalid_q    <= 1'b0;
      m_tlast_q     <= 1'b0;
      m_tid_q       <= '0;
      m_tdest_q     <= '0;
      m_tuser_q     <= '0;
      exp_q         <= '{default: '0};
      accept_cnt_q  <= '0;
      dup_cnt_q     <= '0;
      seq_err_cnt_q <= '0;
      bad_qp_cnt_q  <= '0;
    end else begin
      state_q       <= state_d;
      m_tdata_q     <= m_tdata_d;
      m_tkeep_q     <= m_tkeep_d;
      m_tvalid_q    <= m_tvalid_d;
      m_tlast_q     <= m_tlast_d;
      m_tid_q       <= m_tid_d;
      m_tdest_q     <= m_tdest_d;
      m_tuser_q     <= m_tuser_d;
      exp_q         <= exp_d;
      accept_cnt_q  <= accept_cnt_d;
      dup_cnt_q     <= dup_cnt_d;
      seq_err_cnt_q <= seq_err_cnt_d;
      bad_qp_cnt_q  <= bad_qp_cnt_d;
    end
  end

  assign m_axis_rx_tdata  = m_tdata_q;
  assign m_axis_rx_tkeep  = m_tkeep_q;
  assign m_axis_rx_tvalid = m_tvalid_q;
  assign m_axis_rx_tlast  = m_tlast_q;
  assign m_axis_rx_tid    = m_tid_q;
  assign m_axis_rx_tdest  = m_tdest_q;
  assign m_axis_rx_tuser  = m_tuser_q;

  assign stat_accept_cnt  = accept_cnt_q;
  assign stat_dup_cnt     = dup_cnt_q;
  assign stat_seq_err_cnt = seq_err_cnt_q;
  assign stat_bad_qp_cnt  = bad_qp_cnt_q;

endmodule

// File: tb/tb_mqnic_app_rx_psn_filter.sv
// Directed testbench for mqnic_app_rx_psn_filter.
module tb_mqnic_app_rx_psn_filter;

  localparam int DW  = 512;
  localparam int KW  = 64;
  localparam int IW  = 1;
  localparam int DEW = 8;
  localparam int UW  = 96;
  localparam int QW  = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst;
  logic [DW-1:0]  s_tdata;
  logic [KW-1:0]  s_tkeep;
  logic           s_tvalid;
  logic           s_tready;
  logic           s_tlast;
  logic [IW-1:0]  s_tid;
  logic [DEW-1:0] s_tdest;
  logic [UW-1:0]  s_tuser;
  logic [DW-1:0]  m_tdata;
  logic [KW-1:0]  m_tkeep;
  logic           m_tvalid;
  logic           m_tready;
  logic           m_tlast;
  logic [IW-1:0]  m_tid;
  logic [DEW-1:0] m_tdest;
  logic [UW-1:0]  m_tuser;
  logic           psn_check_en;
  logic           cfg_wr_en;
  logic [QW-1:0]  cfg_wr_qp;
  logic [23:0]    cfg_wr_psn;
  logic [31:0]    stat_accept_cnt;
  logic [31:0]    stat_dup_cnt;
  logic [31:0]    stat_seq_err_cnt;
  logic [31:0]    stat_bad_qp_cnt;

  mqnic_app_rx_psn_filter dut (
    .clk              (clk),
    .rst              (rst),
    .s_axis_rx_tdata  (s_tdata),
    .s_axis_rx_tkeep  (s_tkeep),
    .s_axis_rx_tvalid (s_tvalid),
    .s_axis_rx_tready (s_tready),
    .s_axis_rx_tlast  (s_tlast),
    .s_axis_rx_tid    (s_tid),
    .s_axis_rx_tdest  (s_tdest),
    .s_axis_rx_tuser  (s_tuser),
    .m_axis_rx_tdata  (m_tdata),
    .m_axis_rx_tkeep  (m_tkeep),
    .m_axis_rx_tvalid (m_tvalid),
    .m_axis_rx_tready (m_tready),
    .m_axis_rx_tlast  (m_tlast),
    .m_axis_rx_tid    (m_tid),
    .m_axis_rx_tdest  (m_tdest),
    .m_axis_rx_tuser  (m_tuser),
    .psn_check_en     (psn_check_en),
    .cfg_wr_en        (cfg_wr_en),
    .cfg_wr_qp        (cfg_wr_qp),
    .cfg_wr_psn       (cfg_wr_psn),
    .stat_accept_cnt  (stat_accept_cnt),
    .stat_dup_cnt     (stat_dup_cnt),
    .stat_seq_err_cnt (stat_seq_err_cnt),
    .stat_bad_qp_cnt  (stat_bad_qp_cnt)
  );

  typedef struct {
    logic [DW-1:0]  data;
    logic [KW-1:0]  keep;
    logic           last;
    logic [IW-1:0]  id;
    logic [DEW-1:0] dest;
    logic [UW-1:0]  user;
    int             cyc;
  } beat_t;

  beat_t exp_q[$];
  beat_t out_q[$];

  int chk_cnt  = 0;
  int pass_cnt = 0;
  int cyc      = 0;
  logic [7:0] seed = 8'h10;

  always @(posedge clk) cyc <= cyc + 1;

  // Output beats are captured mid-cycle; a beat seen here handshakes on the next edge.
  always @(negedge clk) begin : mon
    beat_t b;
    if (m_tvalid === 1'b1 && m_tready === 1'b1) begin
      b.data = m_tdata;
      b.keep = m_tkeep;
      b.last = m_tlast;
      b.id   = m_tid;
      b.dest = m_tdest;
      b.user = m_tuser;
      b.cyc  = cyc;
      out_q.push_back(b);
    end
  end

  function automatic logic [DW-1:0] mk_data(input bit hdr, input logic [15:0] et,
                                            input logic [7:0] proto, input logic [15:0] port,
                                            input logic [23:0] qpn, input logic [23:0] psn,
                                            input logic [7:0] sd);
    logic [DW-1:0] d;
    for (int k = 0; k < KW; k++) d[8*k +: 8] = sd + 8'(k * 7);
    if (hdr) begin
      d[8*12 +: 8] = et[15:8];
      d[8*13 +: 8] = et[7:0];
      d[8*23 +: 8] = proto;
      d[8*36 +: 8] = port[15:8];
      d[8*37 +: 8] = port[7:0];
      d[8*47 +: 8] = qpn[23:16];
      d[8*48 +: 8] = qpn[15:8];
      d[8*49 +: 8] = qpn[7:0];
      d[8*51 +: 8] = psn[23:16];
      d[8*52 +: 8] = psn[15:8];
      d[8*53 +: 8] = psn[7:0];
    end
    return d;
  endfunction

  function automatic bit stream_ok();
    if (out_q.size() != exp_q.size()) return 1'b0;
    foreach (exp_q[i]) begin
      if (out_q[i].data !== exp_q[i].data || out_q[i].keep !== exp_q[i].keep ||
          out_q[i].last !== exp_q[i].last || out_q[i].id !== exp_q[i].id ||
          out_q[i].dest !== exp_q[i].dest || out_q[i].user !== exp_q[i].user) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic clear_q();
    exp_q.delete();
    out_q.delete();
  endtask

  // Sends nsend beats of an nbeats-long frame; beats are queued as expected output if exp_pass.
  task automatic send_frame(input logic [15:0] et, input logic [7:0] proto,
                            input logic [15:0] port, input logic [23:0] qpn,
                            input logic [23:0] psn, input int nbeats, input int nsend,
                            input bit exp_pass);
    beat_t b;
    int    t;
    bit    got;
    for (int i = 0; i < nsend; i++) begin
      b.data = mk_data(i == 0, et, proto, port, qpn, psn, seed + 8'(i));
      b.keep = (nbeats > 1 && i == nbeats - 1) ? {32'h0, 32'hFFFF_FFFF} : '1;
      b.last = (i == nbeats - 1);
      b.id   = i[0];
      b.dest = seed ^ 8'(i);
      b.user = {seed, 8'(i), 80'h0123_4567_89AB_CDEF_0F1E};
      s_tdata  = b.data;
      s_tkeep  = b.keep;
      s_tlast  = b.last;
      s_tid    = b.id;
      s_tdest  = b.dest;
      s_tuser  = b.user;
      s_tvalid = 1'b1;
      got = 1'b0;
      t   = 0;
      while (!got && t < 200) begin
        @(negedge clk);
        if (s_tready === 1'b1) got = 1'b1;
        else t++;
      end
      if (!got) begin
        chk_cnt++;
        $display("FAIL send_timeout: s_tready=%b after %0d cycles, required 1", s_tready, t);
        s_tvalid = 1'b0;
        return;
      end
      b.cyc = cyc;
      @(posedge clk);
      #1;
      if (exp_pass) exp_q.push_back(b);
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    seed     = seed + 8'h20;
  endtask

  task automatic drain();
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_cnt++;
    if (s_tready !== 1'b0) $display("FAIL reset_tready: got %b expected 0", s_tready);
    else pass_cnt++;
    chk_cnt++;
    if (m_tvalid !== 1'b0) $display("FAIL reset_tvalid: got %b expected 0", m_tvalid);
    else pass_cnt++;
    chk_cnt++;
    if (stat_accept_cnt !== 32'd0) $display("FAIL reset_accept: got %0d expected 0", stat_accept_cnt);
    else pass_cnt++;
    chk_cnt++;
    if (stat_dup_cnt !== 32'd0) $display("FAIL reset_dup: got %0d expected 0", stat_dup_cnt);
    else pass_cnt++;
    chk_cnt++;
    if (stat_seq_err_cnt !== 32'd0) $display("FAIL reset_seq: got %0d expected 0", stat_seq_err_cnt);
    else pass_cnt++;
    chk_cnt++;
    if (stat_bad_qp_cnt !== 32'd0) $display("FAIL reset_badqp: got %0d expected 0", stat_bad_qp_cnt);
    else pass_cnt++;
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_in_order();
    clear_q();
    for (int p = 0; p < 3; p++) send_frame(16'h0800, 8'h11, 16'h12B7, 24'd3, 24'(p), 3, 3, 1'b1);
    drain();
    chk_cnt++;
    if (stream_ok() !== 1'b1)
      $display("FAIL in_order_stream: got %0d beats, expected %0d exact beats", out_q.size(), exp_q.size());
    else pass_cnt++;
    chk_cnt++;
    if (out_q.size() == 0 || out_q[0].cyc - exp_q[0].cyc !== 1)
      $display("FAIL in_order_latency: got %0d cycles expected 1",
               (out_q.size() == 0) ? -1 : out_q[0].cyc - exp_q[0].cyc);
    else pass_cnt++;
    chk_cnt++;
    if (stat_accept_cnt !== 32'd3) $display("FAIL in_order_accept: got %0d expected 3", stat_accept_cnt);
    else pass_cnt++;
  endtask

  task automatic test_drop();
    clear_q();
    send_frame(16'h0800, 8'h11, 16'h12B7, 24'd3, 24'd2, 3, 3, 1'b0);
    send_frame(16'h0800, 8'h11, 16'h12B7, 24'd3, 24'd5, 3, 3, 1'b0);
    drain();
    chk_cnt++;
    if (out_q.size() != 0) $display("FAIL drop_no_output: got %0d beats expected 0", out_q.size());
    else pass_cnt++;
    chk_cnt++;
    if (stat_dup_cnt !== 32'd1) $display("FAIL drop_dup: got %0d expected 1", stat_dup_cnt);
    else pass_cnt++;
    chk_cnt++;
    if (stat_seq_err_cnt !== 32'd1) $display("FAIL drop_seq: got %0d expected 1", stat_seq_err_cnt);
    else pass_cnt++;
    // Expected PSN must still be 3.
    send_frame(16'h0800, 8'h11, 16'h12B7, 24'd3, 24'd3, 2, 2, 1'b1);
    drain();
    chk_cnt++;
    if (stat_accept_cnt !== 32'd4 || stream_ok() !== 1'b1)
      $display("FAIL drop_exp_kept: accept %0d beats %0d, expected accept 4 beats 2",
               stat_accept_cnt, out_q.size());
    else pass_cnt++;
  endtask

  task automatic test_wrap();
    clear_q();
    cfg_wr_en  = 1'b1;
    cfg_wr_qp  = 4'd7;
    cfg_wr_psn = 24'hFFFFFF;
    @(posedge clk);
    #1;
    cfg_wr_en = 1'b0;
    send_frame(16'h0800, 8'h11, 16'h12B7, 24'd7, 24'hFFFFFF, 2, 2, 1'b1);
    send_frame(16'h0800, 8'h11, 16'h12B7, 24'd7, 24'h000000, 2, 2, 1'b1);
    send_frame(16'h0800, 8'h11, 16'h12B7, 24'd7, 24'h000001, 2, 2, 1'b1);
    drain();
    chk_cnt++;
    if (stream_ok() !== 1'b1)
      $display("FAIL wrap_stream: got %0d beats, expected %0d exact beats", out_q.size(), exp_q.size());
    else pass_cnt++;
    chk_cnt++;
    if (stat_accept_cnt !== 32'd7) $display("FAIL wrap_accept: got %0d expected 7", stat_accept_cnt);
    else pass_cnt++;
  endtask

  task automatic test_non_roce();
    clear_q();
    send_frame(16'h0806, 8'h11, 16'h12B7, 24'd3, 24'd0, 2, 2, 1'b1);
    send_frame(16'h0800, 8'h11, 16'h0035, 24'd3, 24'd0, 2, 2, 1'b1);
    psn_check_en = 1'b0;
    send_frame(16'h0800, 8'h11, 16'h12B7, 24'd3, 24'd100, 2, 2, 1'b1);
    psn_check_en = 1'b1;
    drain();
    chk_cnt++;
    if (stream_ok() !== 1'b1)
      $display("FAIL non_roce_stream: got %0d beats, expected %0d exact beats", out_q.size(), exp_q.size());
    else pass_cnt++;
    chk_cnt++;
    if (stat_accept_cnt !== 32'd7) $display("FAIL non_roce_accept: got %0d expected 7", stat_accept_cnt);
    else pass_cnt++;
    chk_cnt++;
    if (stat_dup_cnt !== 32'd1) $display("FAIL non_roce_dup: got %0d expected 1", stat_dup_cnt);
    else pass_cnt++;
    chk_cnt++;
    if (stat_seq_err_cnt !== 32'd1) $display("FAIL non_roce_seq: got %0d expected 1", stat_seq_err_cnt);
    else pass_cnt++;
    chk_cnt++;
    if (stat_bad_qp_cnt !== 32'd0) $display("FAIL non_roce_badqp: got %0d expected 0", stat_bad_qp_cnt);
    else pass_cnt++;
  endtask

  task automatic test_bad_qp();
    clear_q();
    send_frame(16'h0800, 8'h11, 16'h12B7, 24'h000020, 24'd0, 2, 2, 1'b0);
    // Two single-beat frames back to back exercise staying in the first-beat state.
    send_frame(16'h0800, 8'h11, 16'h12B7, 24'd3, 24'd4, 1, 1, 1'b1);
    send_frame(16'h0800, 8'h11, 16'h12B7, 24'd3, 24'd5, 1, 1, 1'b1);
    drain();
    chk_cnt++;
    if (stat_bad_qp_cnt !== 32'd1) $display("FAIL bad_qp_cnt: got %0d expected 1", stat_bad_qp_cnt);
    else pass_cnt++;
    chk_cnt++;
    if (stream_ok() !== 1'b1)
      $display("FAIL bad_qp_stream: got %0d beats, expected %0d exact beats", out_q.size(), exp_q.size());
    else pass_cnt++;
    chk_cnt++;
    if (stat_accept_cnt !== 32'd9) $display("FAIL bad_qp_accept: got %0d expected 9", stat_accept_cnt);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    bit done;
    clear_q();
    done = 1'b0;
    fork
      begin
        send_frame(16'h0800, 8'h11, 16'h12B7, 24'd3, 24'd6, 4, 4, 1'b1);
        done = 1'b1;
      end
      begin
        int k = 0;
        while (!done && k < 200) begin
          @(posedge clk);
          #1;
          m_tready = ~m_tready;
          k++;
        end
        m_tready = 1'b1;
      end
    join
    drain();
    chk_cnt++;
    if (stream_ok() !== 1'b1)
      $display("FAIL backpressure_stream: got %0d beats, expected %0d exact beats", out_q.size(), exp_q.size());
    else pass_cnt++;
    chk_cnt++;
    if (stat_accept_cnt !== 32'd10) $display("FAIL backpressure_accept: got %0d expected 10", stat_accept_cnt);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_frame();
    clear_q();
    send_frame(16'h0800, 8'h11, 16'h12B7, 24'd3, 24'd7, 4, 2, 1'b1);
    chk_cnt++;
    if (stat_accept_cnt !== 32'd11) $display("FAIL mid_pre_accept: got %0d expected 11", stat_accept_cnt);
    else pass_cnt++;
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk_cnt++;
    if (m_tvalid !== 1'b0) $display("FAIL mid_tvalid: got %b expected 0", m_tvalid);
    else pass_cnt++;
    chk_cnt++;
    if (stat_accept_cnt !== 32'd0) $display("FAIL mid_accept_clr: got %0d expected 0", stat_accept_cnt);
    else pass_cnt++;
    chk_cnt++;
    if (stat_dup_cnt !== 32'd0) $display("FAIL mid_dup_clr: got %0d expected 0", stat_dup_cnt);
    else pass_cnt++;
    chk_cnt++;
    if (stat_seq_err_cnt !== 32'd0) $display("FAIL mid_seq_clr: got %0d expected 0", stat_seq_err_cnt);
    else pass_cnt++;
    chk_cnt++;
    if (stat_bad_qp_cnt !== 32'd0) $display("FAIL mid_badqp_clr: got %0d expected 0", stat_bad_qp_cnt);
    else pass_cnt++;
    rst = 1'b1;
    // Table was cleared, so PSN 0 on QP 3 is in order again.
    send_frame(16'h0800, 8'h11, 16'h12B7, 24'd3, 24'd0, 3, 3, 1'b1);
    drain();
    chk_cnt++;
    if (stream_ok() !== 1'b1)
      $display("FAIL mid_stream: got %0d beats, expected %0d exact beats", out_q.size(), exp_q.size());
    else pass_cnt++;
    chk_cnt++;
    if (stat_accept_cnt !== 32'd1) $display("FAIL mid_post_accept: got %0d expected 1", stat_accept_cnt);
    else pass_cnt++;
    chk_cnt++;
    if (stat_dup_cnt !== 32'd0) $display("FAIL mid_post_dup: got %0d expected 0", stat_dup_cnt);
    else pass_cnt++;
  endtask

  initial begin
    rst          = 1'b0;
    s_tdata      = '0;
    s_tkeep      = '0;
    s_tvalid     = 1'b0;
    s_tlast      = 1'b0;
    s_tid        = '0;
    s_tdest      = '0;
    s_tuser      = '0;
    m_tready     = 1'b1;
    psn_check_en = 1'b1;
    cfg_wr_en    = 1'b0;
    cfg_wr_qp    = '0;
    cfg_wr_psn   = '0;
    test_reset();
    test_in_order();
    test_drop();
    test_wrap();
    test_non_roce();
    test_bad_qp();
    test_back_to_back();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/mqnic_app_rx_psn_filter.md
Name: mqnic_app_rx_psn_filter

Overview:
- RX stage directly upstream of the RoCE RX data processor.
- Parses the first beat of each RX frame for an IPv4/UDP/RoCEv2 BTH header and looks up the expected PSN for the destination QP in an internal per-QP table.
- In-order packets are forwarded unchanged and advance the expected PSN. Duplicate or out-of-sequence packets are dropped whole and counted.
- Non-RoCE frames pass through untouched.

Parameters:
- AXIS_DATA_WIDTH, 512, data width; must be ≥ 512 so the full 54-byte header lies in beat 0.
- AXIS_KEEP_WIDTH, AXIS_DATA_WIDTH/8, tkeep width.
- AXIS_ID_WIDTH, 1, tid width.
- AXIS_DEST_WIDTH, 8, tdest width.
- AXIS_USER_WIDTH, 96, tuser width.
- QP_COUNT, 16, number of tracked QPs; power of 2.
- QP_IDX_WIDTH, $clog2(QP_COUNT), QP table index width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-low (asserted when 0).
- s_axis_rx_tdata/tkeep/tvalid/tready/tlast/tid/tdest/tuser  in (tready out)  per parameters  RX stream from the MAC-side interface.
- m_axis_rx_tdata/tkeep/tvalid/tready/tlast/tid/tdest/tuser  out (tready in)  per parameters  filtered stream to the RX data processor.
- psn_check_en  in  1  0: every frame passes and the table is not updated.
- cfg_wr_en  in  1  table write strobe.
- cfg_wr_qp  in  QP_IDX_WIDTH  table index to write.
- cfg_wr_psn  in  24  expected PSN to load.
- stat_accept_cnt  out  32  RoCE frames accepted.
- stat_dup_cnt  out  32  duplicate frames dropped.
- stat_seq_err_cnt  out  32  future-PSN frames dropped.
- stat_bad_qp_cnt  out  32  frames dropped for out-of-range QPN.

Behaviour:
- Byte k of a beat is tdata[8k+7:8k]. Header fields are big-endian across bytes.
- RoCE classification, evaluated on the first beat only:
  - ethertype bytes 12..13 = 0x0800;
  - IP protocol byte 23 = 0x11;
  - UDP destination port bytes 36..37 = 0x12B7;
  - tkeep[53:0] all ones.
- Extracted fields: QPN = bytes 47..49; PSN = bytes 51..53. Table index = QPN[QP_IDX_WIDTH-1:0].
- Decision on the first beat:
  - Not RoCE, or psn_check_en = 0 → PASS.
  - QPN[23:QP_IDX_WIDTH] ≠ 0 → DROP; increment bad_qp.
  - Otherwise diff = (PSN − exp[idx]) mod 2^24:
    - diff = 0 → PASS; exp[idx] ← exp[idx] + 1 mod 2^24; increment accept.
    - diff[23] = 1 → DROP; increment dup.
    - else → DROP; increment seq_err.
- FSM states: FIRST, PASS, DROP.
  - FIRST: waits for a first-beat handshake and takes the decision.
  - If the first beat has tlast, the frame completes and the FSM stays in FIRST; otherwise it goes to PASS or DROP.
  - PASS and DROP return to FIRST on the handshaked tlast beat.
- Handshake:
  - FIRST/PASS: s_tready = !m_tvalid_reg | m_tready.
  - DROP: s_tready = 1; beats are discarded and m_tvalid is not asserted for them.
  - On a DROP decision the first beat itself is discarded as well.
- Output is a single register stage: latency 1 cycle.
  - All sideband signals are forwarded bit-exact.
  - m_tvalid holds until m_tready; stalls lose no data.
- Table and counter updates occur only on the first-beat handshake, never on stalled cycles.
- Counters are 32-bit and saturate at 0xFFFFFFFF.
- cfg write and a packet update to the same index in the same cycle: the cfg write wins. A cfg write affects only frames whose first beat arrives later.
- Reset (rst = 0):
  - FSM → FIRST; m_tvalid = 0; all exp[] = 0; all counters = 0.
  - A frame in progress when reset is asserted is abandoned. After reset the next beat is treated as a first beat.
- s_tready is 0 during reset.

Decomposition:
- Shared package holds:
  - header byte offsets (ETHTYPE_OFS, IPPROTO_OFS, UDPDP_OFS, QPN_OFS, PSN_OFS, MIN_HDR_BYTES = 54);
  - constants ETHTYPE_IPV4, IPPROTO_UDP, ROCEV2_PORT;
  - the decision enum (PASS / DUP / SEQERR / BADQP).
- One sub-module: mqnic_app_roce_hdr_parse. It is combinational from beat 0 to {is_roce, qpn, psn}. FSM, table and counters live in the top module.

Test Plan:
- Reset; send QP 3 frames with PSN 0, 1, 2 (3 beats each) → all forwarded bit-exact after 1 cycle; exp[3] = 3; accept = 3.
- With exp[3] = 3, send PSN 2 → dropped, dup = 1. Then send PSN 5 → dropped, seq_err = 1. exp[3] stays 3 and m_tvalid is never asserted for either.
- cfg_wr_psn = 0xFFFFFF to QP 7; send PSN 0xFFFFFF then 0x000000 → both accepted; exp[7] = 0x000001 (wrap).
- Non-RoCE frames: ARP (ethertype 0x0806) and UDP port 53 → passed unchanged; counters unchanged.
- QPN 0x000020 with QP_COUNT = 16 → dropped; bad_qp = 1. A 1-beat RoCE frame with tlast on beat 0 → handled, FSM stays in FIRST.
- Backpressure: m_tready toggles 1010… during a 4-beat accepted frame → no beat lost or duplicated. Then assert rst = 0 mid-frame → m_tvalid = 0 next cycle and counters are 0. The following frame is parsed as a new frame.
